// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: multi-account ATM session controller with
// per-account balance, daily withdrawal limit, PIN lockout, timeout.
module atm_session_ctrl #(
  parameter int NUM_ACCTS     = 4,
  parameter int BAL_W         = 16,
  parameter int AMT_W         = 16,
  parameter int INIT_BAL      = 1000,
  parameter int DAILY_LIMIT   = 500,
  parameter int MAX_PIN_TRIES = 3,
  parameter int TIMEOUT_CYC   = 64,
  localparam int ACCT_W = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              card_valid,
  input  logic [ACCT_W-1:0] card_acct,
  input  logic              pin_valid,
  input  logic              pin_ok,
  input  logic              txn_valid,
  input  logic [1:0]        txn_type,
  input  logic [AMT_W-1:0]  amount,
  input  logic              day_rollover,
  output logic [3:0]        state_o,
  output logic [BAL_W-1:0]  balance_o,
  output logic              balance_valid,
  output logic              cash_dispense,
  output logic [AMT_W-1:0]  cash_amount,
  output logic              deposit_accept,
  output logic              card_eject,
  output logic              card_retained,
  output logic              warn_bad_pin,
  output logic              err_insufficient,
  output logic              err_limit,
  output logic              err_overflow,
  output logic              err_timeout
);

  localparam int TR_W  = $clog2(MAX_PIN_TRIES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam int DAY_W = AMT_W + 1;
  // Two extra bits keep limit sums free of wrap.
  localparam int SUM_W = BAL_W + 2;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    GET_PIN      = 4'd1,
    CHECK_PIN    = 4'd2,
    MENU         = 4'd3,
    BAL_SHOW     = 4'd4,
    WITHDRAW_CHK = 4'd5,
    DISPENSE     = 4'd6,
    DEPOSIT      = 4'd7,
    EJECT        = 4'd8,
    RETAIN       = 4'd9
  } state_t;

  state_t state;
  state_t nxt;

  logic [ACCT_W-1:0] acct;
  logic [AMT_W-1:0]  amt;
  logic              pin_good;
  logic [TR_W-1:0]   tries;
  logic [TO_W-1:0]   to_cnt;

  logic [BAL_W-1:0]     bal [NUM_ACCTS];
  logic [DAY_W-1:0]     today [NUM_ACCTS];
  logic [NUM_ACCTS-1:0] blocked;

  logic [BAL_W-1:0] cur_bal;
  logic [DAY_W-1:0] cur_day;
  logic [SUM_W-1:0] wd_sum;
  logic [BAL_W:0]   dep_sum;
  logic             insuff;
  logic             over_lim;
  logic             ovf;
  logic             waiting;
  logic             to_hit;
  logic             last_try;

  // Session-account views and decision conditions.
  always_comb begin
    cur_bal  = bal[acct];
    cur_day  = today[acct];
    wd_sum   = SUM_W'(cur_day) + SUM_W'(amt);
    dep_sum  = {1'b0, cur_bal} + (BAL_W + 1)'(amt);
    insuff   = SUM_W'(amt) > SUM_W'(cur_bal);
    over_lim = wd_sum > SUM_W'(DAILY_LIMIT);
    ovf      = dep_sum[BAL_W];
    waiting  = (state == GET_PIN) || (state == MENU);
    to_hit   = waiting
             && (to_cnt == TO_W'(TIMEOUT_CYC - 1))
             && !((state == GET_PIN) && pin_valid)
             && !((state == MENU) && txn_valid);
    last_try = (tries + TR_W'(1)) == TR_W'(MAX_PIN_TRIES);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  // Next-state decode.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (card_valid)
          nxt = blocked[card_acct] ? RETAIN : GET_PIN;
      end
      GET_PIN: begin
        if (pin_valid)   nxt = CHECK_PIN;
        else if (to_hit) nxt = EJECT;
      end
      CHECK_PIN: begin
        if (pin_good)      nxt = MENU;
        else if (last_try) nxt = RETAIN;
        else               nxt = GET_PIN;
      end
      MENU: begin
        if (txn_valid) begin
          unique case (txn_type)
            2'b00: nxt = EJECT;
            2'b01: nxt = BAL_SHOW;
            2'b10: nxt = WITHDRAW_CHK;
            2'b11: nxt = DEPOSIT;
          endcase
        end else if (to_hit) begin
          nxt = EJECT;
        end
      end
      BAL_SHOW:     nxt = MENU;
      WITHDRAW_CHK: nxt = (insuff || over_lim) ? MENU : DISPENSE;
      DISPENSE:     nxt = MENU;
      DEPOSIT:      nxt = MENU;
      EJECT:        nxt = IDLE;
      RETAIN:       nxt = IDLE;
      default:      nxt = IDLE;
    endcase
  end

  // Session latches: account, amount, PIN verdict and try count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acct     <= '0;
      amt      <= '0;
      pin_good <= 1'b0;
      tries    <= '0;
    end else begin
      if (state == IDLE && card_valid)   acct     <= card_acct;
      if (state == GET_PIN && pin_valid) pin_good <= pin_ok;
      if (state == MENU && txn_valid)    amt      <= amount;
      if (state == CHECK_PIN)
        tries <= pin_good ? '0 : tries + TR_W'(1);
      else if (state == EJECT || state == RETAIN)
        tries <= '0;
    end
  end

  // Inactivity counter, restarted on every state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      to_cnt <= '0;
    else if (nxt != state || !waiting) to_cnt <= '0;
    else                               to_cnt <= to_cnt + TO_W'(1);
  end

  // Per-account balances, daily totals and lockout flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal[i]   <= BAL_W'(INIT_BAL);
        today[i] <= '0;
      end
      blocked <= '0;
    end else begin
      if (day_rollover)
        for (int i = 0; i < NUM_ACCTS; i++) today[i] <= '0;
      if (state == DISPENSE) begin
        bal[acct]   <= cur_bal - BAL_W'(amt);
        today[acct] <= (day_rollover ? '0 : cur_day) + DAY_W'(amt);
      end
      if (state == DEPOSIT && !ovf)
        bal[acct] <= dep_sum[BAL_W-1:0];
      if (state == CHECK_PIN && !pin_good && last_try)
        blocked[acct] <= 1'b1;
    end
  end

  // Error and warning pulses, one cycle after the deciding state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warn_bad_pin     <= 1'b0;
      err_insufficient <= 1'b0;
      err_limit        <= 1'b0;
      err_overflow     <= 1'b0;
      err_timeout      <= 1'b0;
    end else begin
      warn_bad_pin     <= (state == CHECK_PIN) && !pin_good && !last_try;
      err_insufficient <= (state == WITHDRAW_CHK) && insuff;
      err_limit        <= (state == WITHDRAW_CHK) && !insuff && over_lim;
      err_overflow     <= (state == DEPOSIT) && ovf;
      err_timeout      <= to_hit;
    end
  end

  // Moore event outputs decoded from the current state.
  always_comb begin
    state_o        = state;
    balance_valid  = (state == BAL_SHOW);
    balance_o      = balance_valid ? cur_bal : '0;
    cash_dispense  = (state == DISPENSE);
    cash_amount    = cash_dispense ? amt : '0;
    deposit_accept = (state == DEPOSIT) && !ovf;
    card_eject     = (state == EJECT);
    card_retained  = (state == RETAIN);
  end

endmodule
